bip_out_port: RTL and testbench
===============================

# bip_out_port

Parametrised output port for the BIP processor system. Captures accumulator writes (the CPU's `WrAcc` strobe) into an internal FIFO of configurable width and depth. Drains the FIFO over a valid/ready handshake and tells the CPU to stall before the FIFO overflows. Sits between the CPU and the UART/FIFO transmit path, replacing the single-flop `WR_FIFO` strobe with a buffered, back-pressured channel that also has an on-change filter mode.

## Interface
- `DATA_W`, 16, accumulator/data width in bits.
- `PC_W`, 11, program-counter width in bits.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`, derived pointer width; not overridden.

- `CLK`  in  1  system clock; all state updates on rising edge.
- `RESET`  in  1  reset, asynchronous, active-high.
- `CLEAR`  in  1  synchronous flush.
- `ACC`  in  DATA_W  CPU accumulator value.
- `WR_ACC`  in  1  CPU accumulator-write strobe, one cycle per write.
- `PC`  in  PC_W  CPU program counter, sampled with `ACC`.
- `MODE`  in  1  0 = capture every write; 1 = capture only when value differs from last captured.
- `OUT_DATA`  out  DATA_W  head-of-FIFO data (first-word fall-through).
- `OUT_PC`  out  PC_W  head-of-FIFO PC tag; present only with `BIP_OUT_PORT_PC_TAG_EN`.
- `OUT_VALID`  out  1  FIFO not empty.
- `OUT_READY`  in  1  consumer accepts head this cycle.
- `STALL`  out  1  request for the CPU to hold its PC.
- `LEVEL`  out  AW+1  current occupancy, 0..DEPTH.
- `DROP_CNT`  out  8  saturating count of writes lost to a full FIFO.

## Operation
- **Push request:** `WR_ACC && (MODE==0 || !last_valid || ACC != last_data)`.
  - `last_data` / `last_valid` record the most recently *accepted* value.
  - Filtered writes (MODE=1, same value) are neither pushed nor counted as drops.
- **Pop:** `OUT_VALID && OUT_READY`.
- **Push accepted** if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- **Push on full without a pop:** the push is discarded, `DROP_CNT` increments and saturates at 255, and `last_data` is unchanged.
- **Simultaneous push and pop:**
  - On empty: the pop is not possible (`OUT_VALID`=0), so the push is accepted.
  - Otherwise: both take effect and `LEVEL` is unchanged.
- **Pointers:** `AW`-bit read and write pointers wrap modulo `DEPTH`. Full/empty is derived from `LEVEL` (== DEPTH / == 0).
- **`CLEAR`:** has priority over push and pop in the same cycle. It sets `LEVEL`=0, zeroes both pointers, clears `last_valid` and resets `DROP_CNT` to 0. Storage contents need not be cleared.
- **`STALL`:** `LEVEL >= DEPTH-1`, combinational from registered `LEVEL`. The CPU sees it at least one write early. A CPU that ignores it loses data, which is reported via `DROP_CNT`.
- **`OUT_DATA`/`OUT_PC`:** show the entry at the read pointer and are forced to 0 while `OUT_VALID`=0.

## Timing
- **Reset values:** `OUT_VALID`=0, `OUT_DATA`=0, `OUT_PC`=0, `STALL`=0, `LEVEL`=0, `DROP_CNT`=0, `last_valid`=0. Reset is asserted asynchronously and released synchronously to `CLK`.
- **Write latency:** a push accepted at edge k makes `OUT_VALID`=1 and `OUT_DATA`=ACC visible immediately after edge k, i.e. one cycle.
- **Pop timing:** a pop at edge k presents the next entry, or deasserts `OUT_VALID`, right after edge k.
- **Handshake rules:**
  - `OUT_VALID` never drops without a pop or `CLEAR`.
  - Head data is stable while `OUT_VALID && !OUT_READY`.
- **`STALL`:** asserts the cycle after the edge that brings `LEVEL` to DEPTH-1. It deasserts the cycle after `LEVEL` falls below DEPTH-1.
- **Reset mid-operation:** all contents are discarded, and no partial push or pop completes.

## Configuration
- `BIP_OUT_PORT_PC_TAG_EN`
  - **Defined:** each FIFO entry stores `{PC, ACC}` sampled on the accepted push, and `OUT_PC` presents the tag of the head entry.
  - **Undefined:** entries hold `ACC` only, the `OUT_PC` port is absent, and `PC` is an unused input.

## Test plan
- **Reset:** assert `RESET` mid-operation with `LEVEL`=3 → all outputs 0 immediately; after release, `OUT_VALID`=0 and `LEVEL`=0.
- **Basic capture:** MODE=0, DEPTH=8, `OUT_READY`=0, write 0x0001..0x0008 → `LEVEL`=8, `STALL`=1 from the cycle after `LEVEL`=7. A 9th write leaves `DROP_CNT`=1. Draining then returns 0x0001..0x0008 in order.
- **On-change filter:** MODE=1, write 0x00AA, 0x00AA, 0x00BB, 0x00BB, 0x00AA → exactly 3 entries (AA, BB, AA) and `DROP_CNT`=0.
- **Full with concurrent pop:** FIFO full, `WR_ACC`=1 with `OUT_READY`=1 in the same cycle → push accepted, `LEVEL` stays 8, `DROP_CNT` unchanged. Run the pointers around twice to check wrap-around.
- **Flush priority:** `CLEAR` together with push and pop at `LEVEL`=5 → `LEVEL`=0, `OUT_VALID`=0, `DROP_CNT`=0. The next write of the previously captured value is accepted even in MODE=1.
- **PC tag:** with `BIP_OUT_PORT_PC_TAG_EN`, write ACC=0x1234 at PC=0x02A → head shows `OUT_DATA`=0x1234 and `OUT_PC`=0x02A.

Source files
------------

// File: rtl/bip_out_port.sv
// bip_out_port: buffered, back-pressured accumulator output port for the BIP CPU.
// Captures WR_ACC writes into a first-word-fall-through FIFO, drained over
// OUT_VALID/OUT_READY. STALL warns the CPU before overflow; DROP_CNT counts
// writes lost on a full FIFO. MODE=1 captures only values that differ from
// the last accepted one.
// Optional feature: define BIP_OUT_PORT_PC_TAG_EN to store the PC with each
// entry and expose it on OUT_PC.
module bip_out_port #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 11,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic [DATA_W-1:0] ACC,
  input  logic              WR_ACC,
  input  logic [PC_W-1:0]   PC,
  input  logic              MODE,
  output logic [DATA_W-1:0] OUT_DATA,
`ifdef BIP_OUT_PORT_PC_TAG_EN
  output logic [PC_W-1:0]   OUT_PC,
`endif
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              STALL,
  output logic [AW:0]       LEVEL,
  output logic [7:0]        DROP_CNT
);

  localparam int unsigned LW = AW + 1;
`ifdef BIP_OUT_PORT_PC_TAG_EN
  localparam int unsigned EW = PC_W + DATA_W;
`else
  localparam int unsigned EW = DATA_W;
`endif

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic [7:0]        drop_cnt;
  logic [DATA_W-1:0] last_data;
  logic              last_valid;

  logic              push_req_c;
  logic              pop_c;
  logic              full_c;
  logic              push_ok_c;
  logic              drop_c;
  logic [EW-1:0]     entry_c;
  logic [EW-1:0]     head_c;

`ifdef BIP_OUT_PORT_PC_TAG_EN
  assign entry_c = {PC, ACC};
`else
  logic unused_pc_c;
  assign unused_pc_c = ^PC;
  assign entry_c     = ACC;
`endif

  // Handshake and push/pop qualification
  always_comb begin
    push_req_c = WR_ACC && (!MODE || !last_valid || (ACC != last_data));
    full_c     = (level == LW'(DEPTH));
    pop_c      = (level != '0) && OUT_READY;
    push_ok_c  = push_req_c && (!full_c || pop_c);
    drop_c     = push_req_c && full_c && !pop_c;
    head_c     = mem[rd_ptr];
  end

  // Pointers, occupancy, filter history and drop counter; CLEAR beats push/pop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_cnt   <= '0;
      last_data  <= '0;
      last_valid <= 1'b0;
    end else if (CLEAR) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      drop_cnt   <= '0;
      last_valid <= 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_data  <= ACC;
        last_valid <= 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok_c && !pop_c) begin
        level <= level + LW'(1);
      end else if (!push_ok_c && pop_c) begin
        level <= level - LW'(1);
      end
      if (drop_c && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Entry storage; no reset needed since pointers/level define validity
  always_ff @(posedge CLK) begin
    if (push_ok_c && !CLEAR) begin
      mem[wr_ptr] <= entry_c;
    end
  end

  // Output view: head entry, zeroed while empty
  always_comb begin
    OUT_VALID = (level != '0);
    OUT_DATA  = OUT_VALID ? head_c[DATA_W-1:0] : '0;
`ifdef BIP_OUT_PORT_PC_TAG_EN
    OUT_PC    = OUT_VALID ? head_c[DATA_W +: PC_W] : '0;
`endif
    STALL     = (level >= LW'(DEPTH - 1));
    LEVEL     = level;
    DROP_CNT  = drop_cnt;
  end

endmodule

// File: tb/tb_bip_out_port.sv
// Scoreboard bench for bip_out_port (default parameters, DEPTH=8).
module tb_bip_out_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CLEAR;
  logic [15:0] ACC;
  logic        WR_ACC;
  logic [10:0] PC;
  logic        MODE;
  logic [15:0] OUT_DATA;
`ifdef BIP_OUT_PORT_PC_TAG_EN
  logic [10:0] OUT_PC;
`endif
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        STALL;
  logic [3:0]  LEVEL;
  logic [7:0]  DROP_CNT;

  typedef struct {
    logic [15:0] d;
    logic [10:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  bip_out_port dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .ACC(ACC), .WR_ACC(WR_ACC),
    .PC(PC), .MODE(MODE), .OUT_DATA(OUT_DATA),
`ifdef BIP_OUT_PORT_PC_TAG_EN
    .OUT_PC(OUT_PC),
`endif
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .STALL(STALL),
    .LEVEL(LEVEL), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One CPU write; expected entries are queued when the bench predicts acceptance
  task automatic wr(input logic [15:0] v, input logic [10:0] p, input bit accept);
    ACC    = v;
    PC     = p;
    WR_ACC = 1'b1;
    if (accept) sb.push_back('{d: v, pc: p});
    tick();
    WR_ACC = 1'b0;
  endtask

  task automatic drain(input int cycles);
    OUT_READY = 1'b1;
    repeat (cycles) tick();
    OUT_READY = 1'b0;
  endtask

  // Monitor: every accepted head is compared against the scoreboard front
  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY && !CLEAR && !RESET) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'(OUT_DATA), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("head_data", 32'(OUT_DATA), 32'(e.d));
`ifdef BIP_OUT_PORT_PC_TAG_EN
        check("head_pc", 32'(OUT_PC), 32'(e.pc));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1; CLEAR = 1'b0; ACC = '0; WR_ACC = 1'b0; PC = '0;
    MODE = 1'b0; OUT_READY = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("rst_valid", 32'(OUT_VALID), 0);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_data",  32'(OUT_DATA), 0);
    check("rst_stall", 32'(STALL), 0);
    check("rst_drop",  32'(DROP_CNT), 0);

    // Basic capture, stall threshold, overflow drop, in-order drain
    for (int i = 1; i <= 8; i++) begin
      wr(16'(i), 11'(i), 1'b1);
      if (i == 6) check("stall_at6", 32'(STALL), 0);
      if (i == 7) begin
        check("level_at7", 32'(LEVEL), 7);
        check("stall_at7", 32'(STALL), 1);
      end
    end
    check("level_full", 32'(LEVEL), 8);
    check("head_stable", 32'(OUT_DATA), 16'h0001);
    wr(16'h0009, 11'h009, 1'b0);
    check("drop_one", 32'(DROP_CNT), 1);
    check("level_after_drop", 32'(LEVEL), 8);
    drain(8);
    check("basic_empty", 32'(OUT_VALID), 0);
    check("basic_stall_off", 32'(STALL), 0);
    check("basic_sb_empty", 32'(sb.size()), 0);

    // On-change filter
    CLEAR = 1'b1; tick(); CLEAR = 1'b0;
    MODE = 1'b1;
    wr(16'h00AA, 11'h010, 1'b1);
    wr(16'h00AA, 11'h011, 1'b0);
    wr(16'h00BB, 11'h012, 1'b1);
    wr(16'h00BB, 11'h013, 1'b0);
    wr(16'h00AA, 11'h014, 1'b1);
    check("filt_level", 32'(LEVEL), 3);
    check("filt_drop", 32'(DROP_CNT), 0);
    drain(3);
    check("filt_sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset with LEVEL=3
    MODE = 1'b0;
    for (int i = 0; i < 3; i++) wr(16'h0050 + 16'(i), 11'h020, 1'b1);
    check("pre_rst_level", 32'(LEVEL), 3);
    #2 RESET = 1'b1;
    #1;
    check("arst_valid", 32'(OUT_VALID), 0);
    check("arst_level", 32'(LEVEL), 0);
    check("arst_data",  32'(OUT_DATA), 0);
    sb.delete();
    tick();
    RESET = 1'b0;
    tick();
    check("post_rst_valid", 32'(OUT_VALID), 0);
    check("post_rst_level", 32'(LEVEL), 0);

    // Full with concurrent pop, pointers wrapped twice
    for (int i = 1; i <= 8; i++) wr(16'h0100 + 16'(i), 11'(i), 1'b1);
    OUT_READY = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wr(16'h0200 + 16'(k), 11'h100 + 11'(k), 1'b1);
      if (k % 4 == 3) check("conc_level", 32'(LEVEL), 8);
    end
    OUT_READY = 1'b0;
    check("conc_drop", 32'(DROP_CNT), 0);
    wr(16'h0BAD, 11'h7FF, 1'b0);
    check("conc_drop_after", 32'(DROP_CNT), 1);
    drain(8);
    check("conc_sb_empty", 32'(sb.size()), 0);

    // Flush priority over simultaneous push and pop at LEVEL=5
    MODE = 1'b1;
    for (int i = 1; i <= 5; i++) wr(16'h0030 + 16'(i), 11'h030, 1'b1);
    check("flush_pre_level", 32'(LEVEL), 5);
    CLEAR = 1'b1; OUT_READY = 1'b1; ACC = 16'h0036; WR_ACC = 1'b1;
    tick();
    CLEAR = 1'b0; OUT_READY = 1'b0; WR_ACC = 1'b0;
    sb.delete();
    check("flush_level", 32'(LEVEL), 0);
    check("flush_valid", 32'(OUT_VALID), 0);
    check("flush_drop", 32'(DROP_CNT), 0);
    wr(16'h0035, 11'h031, 1'b1);
    check("flush_refill_level", 32'(LEVEL), 1);
    check("flush_refill_data", 32'(OUT_DATA), 16'h0035);
    drain(1);

`ifdef BIP_OUT_PORT_PC_TAG_EN
    // PC tag on head entry
    MODE = 1'b0;
    wr(16'h1234, 11'h02A, 1'b1);
    check("tag_data", 32'(OUT_DATA), 16'h1234);
    check("tag_pc", 32'(OUT_PC), 11'h02A);
    drain(1);
`endif

    check("final_sb_empty", 32'(sb.size()), 0);
    check("final_level", 32'(LEVEL), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
